// File: rtl/alu_pkg.sv
// Shared constants for the multiply/divide sequencer and the 181 ALU interface.
// ALU function codes, sequencer states and op encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD_S       = 4'b1001;
  localparam logic       ALU_ADD_M       = 1'b0;
  localparam logic       ALU_ADD_CIN_N   = 1'b1;

  localparam logic [3:0] ALU_SUB_S       = 4'b0110;
  localparam logic       ALU_SUB_M       = 1'b0;
  localparam logic       ALU_SUB_CIN_N   = 1'b0;

  localparam logic [3:0] ALU_PASSA_S     = 4'b1111;
  localparam logic       ALU_PASSA_M     = 1'b1;
  localparam logic       ALU_PASSA_CIN_N = 1'b1;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned shift-add multiply / restoring divide using an external 181 ALU.
// Ports: clk, reset, start/op/a_in/b_in -> busy/done/result_hi/result_lo/div_by_zero; alu_* ALU drive/return.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cin_n,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout_n
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] rem;
  logic             cy;
  logic             accept;

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    q_d       = q_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_s     = ALU_PASSA_S;
    alu_m     = ALU_PASSA_M;
    alu_cin_n = ALU_PASSA_CIN_N;
    rem       = '0;
    cy        = 1'b0;
    accept    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          d_d   = b_in;
          q_d   = a_in;
          p_d   = '0;
          cnt_d = CW'(WIDTH - 1);
          dbz_d = 1'b0;
          hi_d  = '0;
          lo_d  = '0;
          if (op == OP_DIV && b_in == '0) begin
            dbz_d   = 1'b1;
            hi_d    = a_in;
            lo_d    = '1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        alu_b = d_q;
        if (op_q == OP_MUL) begin
          alu_a = p_q;
          if (q_q[0]) begin
            alu_s     = ALU_ADD_S;
            alu_m     = ALU_ADD_M;
            alu_cin_n = ALU_ADD_CIN_N;
          end
          // Carry out of the add becomes the new P msb.
          cy         = q_q[0] & ~alu_cout_n;
          {p_d, q_d} = {cy, alu_f, q_q[WIDTH-1:1]};
        end else begin
          rem       = {p_q[WIDTH-2:0], q_q[WIDTH-1]};
          alu_a     = rem;
          alu_s     = ALU_SUB_S;
          alu_m     = ALU_SUB_M;
          alu_cin_n = ALU_SUB_CIN_N;
          // Shifted-out msb means the remainder already exceeds D.
          accept    = p_q[WIDTH-1] | ~alu_cout_n;
          p_d       = accept ? alu_f : rem;
          q_d       = {q_q[WIDTH-2:0], accept};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          hi_d    = p_d;
          lo_d    = q_d;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign result_hi   = hi_q;
  assign result_lo   = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed self-checking bench for alu_muldiv_seq.
// A behavioural 181 cascade (ADD/SUB/PASSA) answers the ALU interface.
module tb_alu_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result_hi;
  logic [W-1:0] result_lo;
  logic         div_by_zero;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_s;
  logic         alu_m;
  logic         alu_cin_n;
  logic [W-1:0] alu_f;
  logic         alu_cout_n;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .result_hi  (result_hi),
    .result_lo  (result_lo),
    .div_by_zero(div_by_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_m      (alu_m),
    .alu_cin_n  (alu_cin_n),
    .alu_f      (alu_f),
    .alu_cout_n (alu_cout_n)
  );

  logic [W:0] sum;

  always_comb begin
    sum        = '0;
    alu_f      = alu_a;
    alu_cout_n = 1'b1;
    if (!alu_m && alu_s == 4'b1001 && alu_cin_n) begin
      sum        = {1'b0, alu_a} + {1'b0, alu_b};
      alu_f      = sum[W-1:0];
      alu_cout_n = ~sum[W];
    end else if (!alu_m && alu_s == 4'b0110 && !alu_cin_n) begin
      sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      alu_f      = sum[W-1:0];
      alu_cout_n = ~sum[W];
    end
  end

  // Start one op; cyc returns the cycle count at which done was seen.
  task automatic run_op(input logic o, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int cyc);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero});
    end
    tests++;
    if ({result_hi, result_lo} !== 64'd0) begin
      fails++;
      $display("FAIL reset_results got %h want 0", {result_hi, result_lo});
    end
    tests++;
    if ({alu_s, alu_m, alu_cin_n} !== 6'b111111 || alu_a !== 0 || alu_b !== 0) begin
      fails++;
      $display("FAIL reset_alu got s=%b m=%b c=%b a=%h b=%h want PASSA zeros",
               alu_s, alu_m, alu_cin_n, alu_a, alu_b);
    end
  endtask

  task automatic test_mul;
    int cyc;
    run_op(1'b0, 32'd7, 32'd6, cyc);
    tests++;
    if (cyc !== 33) begin
      fails++;
      $display("FAIL mul_latency got %0d want 33", cyc);
    end
    tests++;
    if (result_hi !== 0 || result_lo !== 42 || div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL mul_7x6 got %h_%h dbz=%b want 0_2a dbz=0",
               result_hi, result_lo, div_by_zero);
    end
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    tests++;
    if (result_hi !== 32'hFFFF_FFFE || result_lo !== 32'h0000_0001) begin
      fails++;
      $display("FAIL mul_max got %h_%h want fffffffe_00000001", result_hi, result_lo);
    end
  endtask

  task automatic test_div;
    int cyc;
    run_op(1'b1, 32'd100, 32'd7, cyc);
    tests++;
    if (cyc !== 33 || result_lo !== 14 || result_hi !== 2) begin
      fails++;
      $display("FAIL div_100_7 got q=%0d r=%0d cyc=%0d want q=14 r=2 cyc=33",
               result_lo, result_hi, cyc);
    end
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, cyc);
    tests++;
    if (result_lo !== 32'hFFFF_FFFF || result_hi !== 0) begin
      fails++;
      $display("FAIL div_max_1 got q=%h r=%h want ffffffff 0", result_lo, result_hi);
    end
    run_op(1'b1, 32'h8000_0000, 32'h8000_0001, cyc);
    tests++;
    if (result_lo !== 0 || result_hi !== 32'h8000_0000) begin
      fails++;
      $display("FAIL div_msb got q=%h r=%h want 0 80000000", result_lo, result_hi);
    end
  endtask

  task automatic test_dbz;
    int cyc;
    run_op(1'b1, 32'd5, 32'd0, cyc);
    tests++;
    if (cyc !== 1) begin
      fails++;
      $display("FAIL dbz_latency got %0d want 1", cyc);
    end
    tests++;
    if (result_lo !== 32'hFFFF_FFFF || result_hi !== 5 || div_by_zero !== 1'b1) begin
      fails++;
      $display("FAIL dbz_5_0 got q=%h r=%h dbz=%b want ffffffff 5 1",
               result_lo, result_hi, div_by_zero);
    end
    @(negedge clk);
    tests++;
    if (div_by_zero !== 1'b1 || result_hi !== 5) begin
      fails++;
      $display("FAIL dbz_hold got dbz=%b r=%h want 1 5", div_by_zero, result_hi);
    end
    run_op(1'b1, 32'd9, 32'd3, cyc);
    tests++;
    if (result_lo !== 3 || result_hi !== 0 || div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL div_9_3 got q=%0d r=%0d dbz=%b want 3 0 0",
               result_lo, result_hi, div_by_zero);
    end
  endtask

  task automatic test_start_held;
    int dones = 0;
    int cyc = 0;
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a_in  = 32'd3;
    b_in  = 32'd3;
    @(negedge clk);
    a_in = 32'd5;
    b_in = 32'd5;
    op   = 1'b1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (done) dones++;
    tests++;
    if (result_lo !== 9 || result_hi !== 0) begin
      fails++;
      $display("FAIL held_3x3 got %h_%h want 0_9", result_hi, result_lo);
    end
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    tests++;
    if (dones !== 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL held_single got dones=%0d busy=%b want 1 0", dones, busy);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL held_restart got busy=%b want 1", busy);
    end
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (result_lo !== 1 || result_hi !== 0) begin
      fails++;
      $display("FAIL held_div_5_5 got q=%h r=%h want 1 0", result_lo, result_hi);
    end
  endtask

  task automatic test_reset_abort;
    int cyc;
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a_in  = 32'd12345;
    b_in  = 32'd678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result_hi !== 0 || result_lo !== 0
        || div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL abort_state got busy=%b done=%b res=%h_%h want 0 0 0_0",
               busy, done, result_hi, result_lo);
    end
    tests++;
    if ({alu_s, alu_m, alu_cin_n} !== 6'b111111 || alu_a !== 0 || alu_b !== 0) begin
      fails++;
      $display("FAIL abort_alu got s=%b m=%b c=%b a=%h want PASSA",
               alu_s, alu_m, alu_cin_n, alu_a);
    end
    reset = 1'b0;
    run_op(1'b0, 32'd2, 32'd3, cyc);
    tests++;
    if (cyc !== 33 || result_lo !== 6 || result_hi !== 0) begin
      fails++;
      $display("FAIL abort_then_2x3 got %h_%h cyc=%0d want 0_6 cyc=33",
               result_hi, result_lo, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_dbz();
    test_start_held();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Iterative unsigned multiply/divide sequencer that is the initiator side of the 74181-style ALU slice interface.
- Each cycle it drives A, B, S[3:0], M and CIN_N into a WIDTH-bit cascade of 181 slices plus 182 lookahead, then consumes F and COUT_N.
- It holds the partial-product / partial-remainder and Q registers and performs the shifts.
- Sits beside the main ALU; the ALU itself is external and combinational, with results returned in the same cycle.

Parameters:
- WIDTH, 32, operand width in bits; must be at least 4 and a multiple of 4.

Ports:
- clk  in  1  clock, all state changes on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  start request; sampled only in IDLE.
- op  in  1  0 = multiply, 1 = divide.
- a_in  in  WIDTH  multiplicand / dividend.
- b_in  in  WIDTH  multiplier / divisor.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse in DONE.
- result_hi  out  WIDTH  product high word / remainder.
- result_lo  out  WIDTH  product low word / quotient.
- div_by_zero  out  1  valid with done.
- alu_a  out  WIDTH  ALU A operand.
- alu_b  out  WIDTH  ALU B operand.
- alu_s  out  4  181 function select S3..S0.
- alu_m  out  1  181 mode (1 = logic).
- alu_cin_n  out  1  181 active-low carry in.
- alu_f  in  WIDTH  ALU result.
- alu_cout_n  in  1  active-low carry out of the top slice.

Behaviour:
- ALU codes, active-high data convention:
  - ADD (F=A+B): S=1001, M=0, CIN_N=1.
  - SUB (F=A-B): S=0110, M=0, CIN_N=0.
  - PASSA (F=A): S=1111, M=1, CIN_N=1.
- Reset: state IDLE, all outputs 0 except alu_s=1111, alu_m=1, alu_cin_n=1 (PASSA). Registers P, Q, D and count are cleared.
- IDLE:
  - ALU driven with PASSA, alu_a=alu_b=0.
  - On start, latch D=b_in and Q=a_in for multiply, or D=b_in and Q=a_in with P=0 for divide. Latch op, set count=WIDTH-1.
  - If op=1 and b_in==0, go to DONE directly with dbz flag set. Otherwise go to RUN.
- RUN, multiply step (shift-add):
  - alu_a=P, alu_b=D.
  - If Q[0]=1, drive ADD; otherwise drive PASSA.
  - Next state: {P,Q} <= {c, F, Q[WIDTH-1:1]}, where c = ~alu_cout_n when ADD, else 0.
- RUN, divide step (restoring):
  - R = {P[WIDTH-2:0], Q[WIDTH-1]} and msb = P[WIDTH-1].
  - alu_a=R, alu_b=D, drive SUB.
  - accept = msb | ~alu_cout_n.
  - P <= accept ? F : R; Q <= {Q[WIDTH-2:0], accept}.
- count decrements each RUN cycle. When count==0 at a step, go to DONE after that step, giving exactly WIDTH RUN cycles.
- DONE:
  - done=1 for one cycle.
  - result_hi=P and result_lo=Q; both are registered and hold until the next accepted start or reset.
  - div_by_zero=dbz.
  - Next state is IDLE.
- Latency: start sampled at cycle 0 gives done at cycle WIDTH+1. Divide-by-zero gives done at cycle 1, with result_hi=a_in, result_lo=all ones, div_by_zero=1.
- div_by_zero is cleared on the next accepted start; otherwise it holds with the results.
- start while busy is ignored and causes no state change.
- start in the DONE cycle is ignored; it is accepted only once back in IDLE.
- Reset asserted mid-operation aborts in the same cycle: next state IDLE and all outputs at reset values. There is no done pulse.
- Arithmetic is unsigned only. The multiply product is 2*WIDTH bits and exact, since the carry is folded into the P msb. No overflow is possible.
- The ALU interface is purely combinational from registered state. Outputs never depend combinationally on alu_f.

Decomposition:
- Shared package alu_pkg:
  - ALU code constants ALU_ADD_S, ALU_SUB_S, ALU_PASSA_S with their M and CIN_N values.
  - State enum {IDLE, RUN, DONE}.
  - Op encoding OP_MUL=0, OP_DIV=1.
- No sub-module is required.
- For simulation the bench instantiates the existing 181 part as a WIDTH/4 slice ripple, or a behavioural equivalent, as the ALU responder.

Test Plan:
- Multiply 7*6, WIDTH=32, start at cycle 0 -> done at cycle 33, result_hi=0, result_lo=42, div_by_zero=0.
- Multiply FFFFFFFF*FFFFFFFF -> result_hi=FFFFFFFE, result_lo=00000001. Checks carry fold via alu_cout_n.
- Divide 100/7 -> result_lo=14, result_hi=2. Divide FFFFFFFF/1 -> result_lo=FFFFFFFF, result_hi=0. Divide 80000000/80000001 -> result_lo=0, result_hi=80000000.
- Divide 5/0 -> done at cycle 1, result_lo=FFFFFFFF, result_hi=5, div_by_zero=1. A following 9/3 -> result_lo=3, div_by_zero=0.
- start pulses held high through RUN and DONE while multiplying 3*3 -> exactly one done, result_lo=9, with the next accepted start only after returning to IDLE.
- reset asserted at RUN cycle 10 of 12345*678 -> next cycle busy=0, done=0, results 0, ALU at PASSA. A fresh 2*3 then yields 6.
